// File: rtl/stack_drain.sv
// stack_drain: pops a LIFO until empty and presents one-hot-decoded entries on a valid/ready port.
// Optional STACK_DRAIN_CNT_EN adds o_drain_cnt, a saturating count of accepted entries.
module stack_drain #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_stk_empty,
  input  logic [DATA_WIDTH-1:0]      i_stk_data,
  output logic                       o_stk_pop,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [DATA_WIDTH-1:0]      o_out_data,
  output logic [2**DATA_WIDTH-1:0]   o_out_onehot,
  output logic                       o_busy,
  output logic                       o_done
`ifdef STACK_DRAIN_CNT_EN
  ,
  output logic [$clog2(DEPTH):0]     o_drain_cnt
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_PRES} state_t;
  state_t r_state, w_next;
  logic w_xfer, w_go;
  logic [2**DATA_WIDTH-1:0] w_onehot;
  assign w_go     = (r_state == S_IDLE) & i_start & ~i_abort;
  assign w_xfer   = (r_state == S_PRES) & o_out_valid & i_out_ready & ~i_abort;
  assign w_onehot = {{(2**DATA_WIDTH-1){1'b0}}, 1'b1} << i_stk_data;
  assign o_busy   = r_state != S_IDLE;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    o_stk_pop = 1'b0;
    case (r_state)
      S_IDLE: w_next = w_go ? S_POP : S_IDLE;
      S_POP: begin
        o_stk_pop = ~i_stk_empty & ~i_abort;
        w_next    = i_stk_empty ? S_IDLE : S_CAPT;
      end
      S_CAPT: w_next = S_PRES;
      S_PRES: w_next = w_xfer ? S_POP : S_PRES;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_out_valid  <= 1'b0;
      o_out_data   <= '0;
      o_out_onehot <= '0;
      o_done       <= 1'b0;
    end else begin
      o_done <= (r_state == S_POP) & i_stk_empty & ~i_abort;
      if (i_abort) o_out_valid <= 1'b0;
      else if (r_state == S_CAPT) begin
        o_out_data   <= i_stk_data;
        o_out_onehot <= w_onehot;
        o_out_valid  <= 1'b1;
      end else if (w_xfer) o_out_valid <= 1'b0;
    end
`ifdef STACK_DRAIN_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)                       o_drain_cnt <= '0;
    else if (w_go)                   o_drain_cnt <= '0;
    else if (w_xfer & ~&o_drain_cnt) o_drain_cnt <= o_drain_cnt + 1'b1;
`endif
endmodule
